// File: rtl/instr_fetch.sv
// Program counter and instruction fetch for the 9-bit ISA: instruction memory,
// 16-entry jump LUT and IDLE/RUN/DONE control. Optional macro FETCH_CYCLE_CNT_EN.
module instr_fetch #(
  parameter int          PC_W    = 10,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            pc_jmp_en,
  input  logic [3:0]      LutPointer,
  input  logic            lut_wr_en,
  input  logic [3:0]      lut_wr_addr,
  input  logic [PC_W-1:0] lut_wr_data,
  input  logic            imem_wr_en,
  input  logic [PC_W-1:0] imem_wr_addr,
  input  logic [8:0]      imem_wr_data,
  output logic [8:0]      instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic            Done,
  output logic [15:0]     cycle_cnt
);

  localparam int DEPTH = 1 << PC_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Start/Done handshake: Start is level-sampled at a rising edge in IDLE or
  // DONE and launches execution at PC 0; it is ignored in RUN. Done is high
  // exactly while the FSM sits in DONE and drops on the edge that restarts.
  state_t          state, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            restart;

  logic [8:0]      imem [DEPTH];
  logic [PC_W-1:0] lut  [16];
  logic [8:0]      fetched;
  logic            at_last;

  assign fetched = imem[pc_q];
  assign at_last = (pc_q == {PC_W{1'b1}});

  always_comb begin
    state_d   = state;
    pc_d      = pc_q;
    restart   = 1'b0;
    instr_out = {HALT_OP, 3'b000};
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          restart = 1'b1;
        end
      end
      RUN: begin
        instr_out = fetched;
        // Halt wins over a jump the decoder may raise on the same word.
        if (fetched[8:3] == HALT_OP) begin
          state_d = DONE;
        end else if (pc_jmp_en) begin
          pc_d = lut[LutPointer];
        end else if (at_last) begin
          state_d = DONE;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_d;
      pc_q  <= pc_d;
    end
  end

  // A jump in the same cycle reads the pre-write entry because the read is
  // combinational from the current register contents.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) lut[i] <= '0;
    end else if (lut_wr_en) begin
      lut[lut_wr_addr] <= lut_wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_n && imem_wr_en) imem[imem_wr_addr] <= imem_wr_data;
  end

  assign pc_out = pc_q;
  assign Done   = (state == DONE);

`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (state == RUN && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = 16'd0;
`endif

endmodule
